can_bit_timing_ctrl: RTL and testbench
======================================

# can_bit_timing_ctrl

Bit-timing sequencer for the CAN timing module. It divides the system clock into time quanta and steps each nominal bit through SYNC, SEG1 and SEG2. It produces the sample-point and bit-start strobes consumed by the bit stream processor. It restarts the bit on a hard-sync request from the hard-sync/bus-idle detector, and optionally applies SJW-limited resynchronisation on recessive-to-dominant edges.

## Interface
Parameters:
- BRP_W, 6, width of baud-rate prescaler field.
- TSEG1_W, 4, width of SEG1 length field.
- TSEG2_W, 3, width of SEG2 length field.
- SJW_W, 2, width of SJW field.

Ports:
- clock, input, 1, system clock. All logic runs on its rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- enable, input, 1, controller enable. Low forces IDLE.
- brp, input, BRP_W, one tq = brp+1 clocks.
- tseg1, input, TSEG1_W, SEG1 (prop+phase1) = tseg1+1 tq.
- tseg2, input, TSEG2_W, SEG2 = tseg2+1 tq.
- sjw, input, SJW_W, sync jump width = sjw+1 tq.
- rx_bit, input, 1, synchronised bus level.
- falling_edge, input, 1, one-clock strobe marking a recessive-to-dominant edge.
- hard_sync_request, input, 1, one-clock strobe from the hard-sync block.
- tq_tick, output, 1, high in the last clock of every tq.
- bit_start, output, 1, high in the first clock of SYNC.
- sample_point, output, 1, high in the first clock of SEG2.
- sample_bit, output, 1, rx_bit captured at the sample point.
- seg_state, output, 2, state encoding: IDLE=0, SYNC=1, SEG1=2, SEG2=3.
- resync_done, output, 1, a resync has been applied in the current bit.

## Operation
- States: IDLE, SYNC (1 tq), SEG1 (tseg1+1+ext tq), SEG2 (tseg2+1 tq).
- The prescaler counts 0..brp_q. tq_tick is asserted when count==brp_q. State and segment counters advance only on tq_tick.
- brp, tseg1, tseg2 and sjw are latched into *_q registers on every SYNC entry. Changes mid-bit take effect at the next bit.
- IDLE: leave only on hard_sync_request with enable high.
- Transitions: SYNC→SEG1 after 1 tq. SEG1→SEG2 after its length. SEG2→SYNC after its length.
- Hard sync: hard_sync_request with enable high, in any state, forces the next state to SYNC and the prescaler to 0, and clears resync_done and the SEG1 extension. Hard sync has the highest priority.
- The SEG1 extension ext is 0..sjw_q+1 and is cleared at SYNC entry.
- On the sample point, sample_bit is loaded with rx_bit.
- enable low: next state IDLE, all counters 0, strobes 0. sample_bit and the *_q registers hold.
- Phase error (resync feature only): applies on falling_edge without hard_sync_request while resync_done==0.
  - In SYNC: ignored; resync_done stays 0.
  - In SEG1 at segment count c: e = c+1; ext = min(e, sjw_q+1); resync_done set.
  - In SEG2 with r tq remaining, including the current tq, and r <= sjw_q+1: restart at SYNC next clock with prescaler 0; resync_done is cleared by the SYNC entry.
  - In SEG2 with r > sjw_q+1: SEG2 is shortened by sjw_q+1 tq; resync_done set.
- Only one resync is applied per bit. Further edges are ignored until SYNC.
- Widths: the SEG1 limit is computed at TSEG1_W+1 bits so that tseg1+1+ext cannot wrap. Max 16+4 = 20 at defaults.

## Timing
- All outputs are registered.
- Reset values: tq_tick=0, bit_start=0, sample_point=0, sample_bit=1 (recessive), seg_state=IDLE, resync_done=0. All counters and *_q registers are 0.
- bit_start is high in the clock immediately after the hard_sync_request clock.
- Nominal bit length is (1+tseg1+1+tseg2+1)·(brp+1) clocks, measured bit_start to bit_start.
- sample_point follows bit_start by (1+tseg1+1+ext)·(brp+1) clocks.
- Simultaneous hard_sync_request and falling_edge: hard sync only.
- Simultaneous SEG2 restart and tq_tick: restart wins.
- Reset mid-bit: immediate return to reset values. No strobe is emitted.

## Configuration
- CAN_RESYNC_EN defined: phase-error resynchronisation is implemented as described.
- CAN_RESYNC_EN undefined:
  - falling_edge is ignored except as already folded into hard_sync_request.
  - ext is always 0 and resync_done is tied 0.
  - The bit length is fixed.

## Test plan
All scenarios use brp=1, tseg1=5, tseg2=2, sjw=1 unless stated.
- Reset then hard_sync_request:
  - bit_start in the next clock; sample_point 14 clocks later; next bit_start 20 clocks after the first.
  - tq_tick every 2 clocks.
  - sample_bit tracks rx_bit.
- Late edge in SEG1 (CAN_RESYNC_EN):
  - Edge at SEG1 count 0: sample_point at 16 clocks.
  - Edge at SEG1 count 4: ext clamps to 2, so sample_point at 18; bit length 24.
- Early edge in SEG2 with 1 tq remaining: SYNC and bit_start next clock. A second edge in the following SEG1 still resyncs once (resync_done cleared).
- Two edges in one SEG1: only the first applies. resync_done stays 1 until bit_start.
- hard_sync_request and falling_edge in the same clock mid-SEG1: bit restarts (bit_start next clock), no extension.
- enable dropped mid-SEG2: seg_state=IDLE next clock and no strobes. brp changed to 3 mid-bit: takes effect only from the next bit_start (tq = 4 clocks).
- Without CAN_RESYNC_EN: edges in SEG1 leave the bit length at 20 clocks.

Source files
------------

// File: rtl/can_bit_timing_ctrl.sv
// CAN bit-timing sequencer: tq prescaler, SYNC/SEG1/SEG2 stepping, hard sync.
// Define CAN_RESYNC_EN to add SJW-limited resynchronisation on falling edges.
module can_bit_timing_ctrl #(
  parameter int BRP_W   = 6,
  parameter int TSEG1_W = 4,
  parameter int TSEG2_W = 3,
  parameter int SJW_W   = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [BRP_W-1:0]   brp,
  input  logic [TSEG1_W-1:0] tseg1,
  input  logic [TSEG2_W-1:0] tseg2,
  input  logic [SJW_W-1:0]   sjw,
  input  logic               rx_bit,
  input  logic               falling_edge,
  input  logic               hard_sync_request,
  output logic               tq_tick,
  output logic               bit_start,
  output logic               sample_point,
  output logic               sample_bit,
  output logic [1:0]         seg_state,
  output logic               resync_done
);
  localparam int CNT_W = TSEG1_W + 1;
  localparam int EXT_W = SJW_W + 1;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SYNC = 2'd1;
  localparam logic [1:0] ST_SEG1 = 2'd2;
  localparam logic [1:0] ST_SEG2 = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [BRP_W-1:0]   presc_q, presc_d, brp_q, brp_d;
  logic [TSEG1_W-1:0] tseg1_q, tseg1_d;
  logic [TSEG2_W-1:0] tseg2_q, tseg2_d;
  logic [SJW_W-1:0]   sjw_q, sjw_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_eff;
  logic [EXT_W-1:0]   ext_q, ext_d;
  logic rsd_q, rsd_d, tick_q, tick_d, bstart_q, bstart_d;
  logic spt_q, spt_d, sbit_q, sbit_d;
  logic sync_entry, restart;

`ifdef CAN_RESYNC_EN
  logic [EXT_W-1:0] sjw1;
  logic [CNT_W-1:0] seg2_rem, cnt_p1;
  assign sjw1     = EXT_W'(sjw_q) + EXT_W'(1);
  assign seg2_rem = CNT_W'(tseg2_q) + CNT_W'(1) - cnt_q;
  assign cnt_p1   = cnt_q + CNT_W'(1);
`else
  logic unused_resync;
  assign unused_resync = ^{falling_edge, sjw_q};
`endif

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    cnt_d      = cnt_q;
    cnt_eff    = cnt_q;
    ext_d      = ext_q;
    rsd_d      = rsd_q;
    brp_d      = brp_q;
    tseg1_d    = tseg1_q;
    tseg2_d    = tseg2_q;
    sjw_d      = sjw_q;
    spt_d      = 1'b0;
    sync_entry = 1'b0;
    restart    = 1'b0;
    sbit_d     = (enable && spt_q) ? rx_bit : sbit_q;

    if (!enable) begin
      state_d = ST_IDLE;
      presc_d = '0;
      cnt_d   = '0;
      ext_d   = '0;
      rsd_d   = 1'b0;
    end else if (hard_sync_request) begin
      sync_entry = 1'b1;
    end else if (state_q != ST_IDLE) begin
      presc_d = tick_q ? '0 : presc_q + BRP_W'(1);
`ifdef CAN_RESYNC_EN
      // one phase correction per bit: lengthen SEG1, or shorten/cut SEG2
      if (falling_edge && !rsd_q) begin
        if (state_q == ST_SEG1) begin
          ext_d = (cnt_p1 > CNT_W'(sjw1)) ? sjw1 : EXT_W'(cnt_p1);
          rsd_d = 1'b1;
        end else if (state_q == ST_SEG2) begin
          if (seg2_rem <= CNT_W'(sjw1)) begin
            restart = 1'b1;
          end else begin
            cnt_eff = cnt_q + CNT_W'(sjw1);
            rsd_d   = 1'b1;
          end
        end
      end
`endif
      if (restart) begin
        sync_entry = 1'b1;
      end else if (tick_q) begin
        case (state_q)
          ST_SYNC: begin
            state_d = ST_SEG1;
            cnt_d   = '0;
          end
          ST_SEG1: begin
            if (cnt_eff == CNT_W'(tseg1_q) + CNT_W'(ext_d)) begin
              state_d = ST_SEG2;
              cnt_d   = '0;
              spt_d   = 1'b1;
            end else begin
              cnt_d = cnt_eff + CNT_W'(1);
            end
          end
          ST_SEG2: begin
            if (cnt_eff == CNT_W'(tseg2_q)) sync_entry = 1'b1;
            else cnt_d = cnt_eff + CNT_W'(1);
          end
          default: ;
        endcase
      end else begin
        cnt_d = cnt_eff;
      end
    end

    // new bit: restart prescaler and pick up the timing fields for this bit
    if (sync_entry) begin
      state_d = ST_SYNC;
      presc_d = '0;
      cnt_d   = '0;
      ext_d   = '0;
      rsd_d   = 1'b0;
      spt_d   = 1'b0;
      brp_d   = brp;
      tseg1_d = tseg1;
      tseg2_d = tseg2;
      sjw_d   = sjw;
    end
    bstart_d = sync_entry;
    tick_d   = (state_d != ST_IDLE) && (presc_d == brp_d);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      presc_q  <= '0;
      cnt_q    <= '0;
      ext_q    <= '0;
      rsd_q    <= 1'b0;
      brp_q    <= '0;
      tseg1_q  <= '0;
      tseg2_q  <= '0;
      sjw_q    <= '0;
      tick_q   <= 1'b0;
      bstart_q <= 1'b0;
      spt_q    <= 1'b0;
      sbit_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      ext_q    <= ext_d;
      rsd_q    <= rsd_d;
      brp_q    <= brp_d;
      tseg1_q  <= tseg1_d;
      tseg2_q  <= tseg2_d;
      sjw_q    <= sjw_d;
      tick_q   <= tick_d;
      bstart_q <= bstart_d;
      spt_q    <= spt_d;
      sbit_q   <= sbit_d;
    end
  end

  assign tq_tick      = tick_q;
  assign bit_start    = bstart_q;
  assign sample_point = spt_q;
  assign sample_bit   = sbit_q;
  assign seg_state    = state_q;
  assign resync_done  = rsd_q;
endmodule

// File: tb/tb_can_bit_timing_ctrl.sv
// Bench for can_bit_timing_ctrl: directed bit-length checks plus random traffic
// against a clock-position model of the nominal bit.
module tb_can_bit_timing_ctrl;
  localparam int BRP_W   = 6;
  localparam int TSEG1_W = 4;
  localparam int TSEG2_W = 3;
  localparam int SJW_W   = 2;
`ifdef CAN_RESYNC_EN
  localparam bit RES = 1'b1;
`else
  localparam bit RES = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n, enable, rx_bit, falling_edge, hard_sync_request;
  logic [BRP_W-1:0]   brp;
  logic [TSEG1_W-1:0] tseg1;
  logic [TSEG2_W-1:0] tseg2;
  logic [SJW_W-1:0]   sjw;
  logic tq_tick, bit_start, sample_point, sample_bit, resync_done;
  logic [1:0] seg_state;
  logic [6:0] dut_vec;

  always #5 clock = ~clock;

  can_bit_timing_ctrl #(.BRP_W(BRP_W), .TSEG1_W(TSEG1_W), .TSEG2_W(TSEG2_W), .SJW_W(SJW_W)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .brp(brp), .tseg1(tseg1),
    .tseg2(tseg2), .sjw(sjw), .rx_bit(rx_bit), .falling_edge(falling_edge),
    .hard_sync_request(hard_sync_request), .tq_tick(tq_tick), .bit_start(bit_start),
    .sample_point(sample_point), .sample_bit(sample_bit), .seg_state(seg_state),
    .resync_done(resync_done)
  );

  assign dut_vec = {tq_tick, bit_start, sample_point, sample_bit, seg_state, resync_done};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  // Model: m_p = clocks since bit_start; bit = 1 + L1 + (t2+1) - short tq.
  bit m_run, m_rsd, m_sbit;
  int m_p, m_brp, m_t1, m_t2, m_sjw, m_ext, m_short;

  function automatic int m_l1();
    return m_t1 + 1 + m_ext;
  endfunction

  function automatic int m_bit_tq();
    return 1 + m_l1() + m_t2 + 1 - m_short;
  endfunction

  function automatic logic [6:0] m_out();
    int tq, q;
    logic [1:0] seg;
    if (!m_run) return {3'b000, m_sbit, 2'd0, 1'b0};
    tq  = m_brp + 1;
    q   = m_p / tq;
    seg = (q == 0) ? 2'd1 : (q < 1 + m_l1()) ? 2'd2 : 2'd3;
    return {(m_p % tq) == tq - 1, m_p == 0, m_p == (1 + m_l1()) * tq, m_sbit, seg, m_rsd};
  endfunction

  task automatic m_reset();
    m_run = 0; m_rsd = 0; m_sbit = 1; m_p = 0; m_ext = 0; m_short = 0;
    m_brp = 0; m_t1 = 0; m_t2 = 0; m_sjw = 0;
  endtask

  task automatic m_start();
    m_run = 1; m_p = 0; m_ext = 0; m_short = 0; m_rsd = 0;
    m_brp = int'(brp); m_t1 = int'(tseg1); m_t2 = int'(tseg2); m_sjw = int'(sjw);
  endtask

  task automatic m_step(input bit en, input bit hs, input bit fe, input bit rx);
    int tq, q, r;
    bit restart;
    restart = 0;
    if (en && m_run && m_p == (1 + m_l1()) * (m_brp + 1)) m_sbit = rx;
    if (!en) begin
      m_run = 0; m_rsd = 0; m_ext = 0; m_short = 0;
    end else if (hs) begin
      m_start();
    end else if (m_run) begin
      tq = m_brp + 1;
      q  = m_p / tq;
      if (RES && fe && !m_rsd && q > 0) begin
        if (q < 1 + m_l1()) begin
          m_ext = (q < m_sjw + 1) ? q : m_sjw + 1;
          m_rsd = 1;
        end else begin
          r = m_bit_tq() - q;
          if (r <= m_sjw + 1) restart = 1;
          else begin
            m_short = m_sjw + 1;
            m_rsd   = 1;
          end
        end
      end
      if (restart) m_start();
      else begin
        m_p++;
        if (m_p == m_bit_tq() * tq) m_start();
      end
    end
  endtask

  task automatic cycle(input bit en, input bit hs, input bit fe, input bit rx);
    enable = en; hard_sync_request = hs; falling_edge = fe; rx_bit = rx;
    m_step(en, hs, fe, rx);
    @(posedge clock); #1;
    check("cyc", 32'(dut_vec), 32'(m_out()));
  endtask

  // Runs one bit; t counts observed clocks with t=1 at bit_start.
  task automatic run_bit(input bit do_hs, input int fe_a, input int fe_b, input int hs_at,
                         input int brp_at, output int sp, output int len);
    sp = -1; len = -1;
    if (do_hs) begin
      cycle(1, 1, 0, 1'($urandom_range(0, 1)));
      check("bs_after_hs", 32'(bit_start), 1);
    end
    for (int t = 1; t <= 80; t++) begin
      if (sample_point && sp < 0) sp = t - 1;
      if (bit_start && t > 1) begin
        len = t - 1;
        break;
      end
      if (t == brp_at) brp = 6'd3;
      cycle(1, t == hs_at, (t == fe_a) || (t == fe_b), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    int sp, len;
    reset_n = 0; enable = 0; rx_bit = 1; falling_edge = 0; hard_sync_request = 0;
    brp = 6'd1; tseg1 = 4'd5; tseg2 = 3'd2; sjw = 2'd1;
    m_reset();
    repeat (3) @(posedge clock);
    #1;
    check("reset", 32'(dut_vec), 32'(7'b0001000));
    reset_n = 1;
    cycle(1, 0, 0, 1);
    cycle(1, 0, 1, 0);

    run_bit(1, 0, 0, 0, 0, sp, len);
    check("nom_sp", sp, 14);  check("nom_len", len, 20);
    run_bit(0, 3, 0, 0, 0, sp, len);
    check("c0_sp", sp, RES ? 16 : 14);  check("c0_len", len, RES ? 22 : 20);
    run_bit(0, 11, 0, 0, 0, sp, len);
    check("c4_sp", sp, RES ? 18 : 14);  check("c4_len", len, RES ? 24 : 20);
    run_bit(0, 19, 0, 0, 0, sp, len);
    check("seg2_len", len, RES ? 19 : 20);
    run_bit(0, 3, 0, 0, 0, sp, len);
    check("after_rs_sp", sp, RES ? 16 : 14);
    run_bit(0, 3, 7, 0, 0, sp, len);
    check("two_sp", sp, RES ? 16 : 14);  check("two_len", len, RES ? 22 : 20);
    run_bit(0, 7, 0, 7, 0, sp, len);
    check("hs_fe_sp", sp, -1);  check("hs_fe_len", len, 7);
    run_bit(0, 0, 0, 0, 0, sp, len);
    check("post_hs_sp", sp, 14);  check("post_hs_len", len, 20);

    repeat (15) cycle(1, 0, 0, 1'($urandom_range(0, 1)));
    check("in_seg2", 32'(seg_state), 3);
    cycle(0, 0, 0, 1);
    check("dis_idle", 32'(seg_state), 0);
    check("dis_strb", 32'({tq_tick, bit_start, sample_point}), 0);
    repeat (3) cycle(0, 0, 0, 0);

    run_bit(1, 0, 0, 0, 5, sp, len);
    check("brp_old_len", len, 20);
    run_bit(0, 0, 0, 0, 0, sp, len);
    check("brp_new_sp", sp, 28);  check("brp_new_len", len, 40);

    repeat (5) cycle(1, 0, 0, 0);
    #2 reset_n = 0;
    #1 check("rst_mid", 32'(dut_vec), 32'(7'b0001000));
    m_reset();
    @(posedge clock); #1;
    reset_n = 1;

    cycle(1, 1, 0, 1);
    for (int i = 0; i < 5000; i++) begin
      brp   = 6'($urandom_range(0, 3));
      tseg1 = 4'($urandom_range(0, 15));
      tseg2 = 3'($urandom_range(0, 7));
      sjw   = 2'($urandom_range(0, 3));
      cycle($urandom_range(0, 299) != 0, $urandom_range(0, 199) == 0,
            $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
